// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipe
//  Purpose  : Pipelined carry-lookahead adder/subtractor, one STAGE_BITS
//             slice resolved per stage with 4-bit group lookahead.
//  Revision : 1.0  initial release
// ============================================================================
module cla_pipe #(
    parameter int WIDTH      = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);
    localparam int LAT = WIDTH / STAGE_BITS;
    localparam int NG  = STAGE_BITS / 4;

    logic             w_adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ov_q;

    assign w_adv    = ~out_valid_q | out_ready;
    assign in_ready = w_adv;

    // Stage k owns the rank-k registers: x_q carries finished sum slices
    // below slice k and raw A above it; b_q keeps only the unconsumed B slices.
    for (genvar k = 0; k < LAT; k++) begin : g_stage
        localparam int BW = WIDTH - k * STAGE_BITS;

        logic                  v_q;
        logic [WIDTH-1:0]      x_q;
        logic [BW-1:0]         b_q;
        logic                  c_q;
        logic [STAGE_BITS-1:0] w_g;
        logic [STAGE_BITS-1:0] w_p;
        logic [STAGE_BITS-1:0] w_c;
        logic [NG-1:0]         w_gg;
        logic [NG-1:0]         w_gp;
        logic [NG:0]           w_gc;
        logic [WIDTH-1:0]      w_x;

        if (k == 0) begin : g_src
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (w_adv) begin
                    v_q <= in_valid;
                    x_q <= a;
                    b_q <= sub ? ~b : b;
                    c_q <= sub | ci;
                end
            end
        end else begin : g_src
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                    x_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                end else if (w_adv) begin
                    v_q <= g_stage[k-1].v_q;
                    x_q <= g_stage[k-1].w_x;
                    b_q <= g_stage[k-1].b_q[WIDTH-(k-1)*STAGE_BITS-1:STAGE_BITS];
                    c_q <= g_stage[k-1].w_gc[NG];
                end
            end
        end

        always_comb begin : p_cla
            logic v_acc;
            logic v_pp;
            v_acc = 1'b0;
            v_pp  = 1'b1;
            w_g   = x_q[k*STAGE_BITS +: STAGE_BITS] & b_q[STAGE_BITS-1:0];
            w_p   = x_q[k*STAGE_BITS +: STAGE_BITS] ^ b_q[STAGE_BITS-1:0];
            w_gg  = '0;
            w_gp  = '0;
            w_gc  = '0;
            w_c   = '0;
            w_x   = x_q;
            for (int j = 0; j < NG; j++) begin
                w_gg[j] = w_g[4*j+3]
                        | (w_p[4*j+3] & w_g[4*j+2])
                        | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                        | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
                w_gp[j] = &w_p[4*j +: 4];
            end
            // Group carries in flat sum-of-products form, no chain between groups.
            w_gc[0] = c_q;
            for (int j = 0; j < NG; j++) begin
                v_acc = 1'b0;
                v_pp  = 1'b1;
                for (int i = j; i >= 0; i--) begin
                    v_acc = v_acc | (w_gg[i] & v_pp);
                    v_pp  = v_pp & w_gp[i];
                end
                w_gc[j+1] = v_acc | (v_pp & c_q);
            end
            for (int j = 0; j < NG; j++) begin
                w_c[4*j] = w_gc[j];
                for (int i = 1; i < 4; i++) begin
                    v_acc = 1'b0;
                    v_pp  = 1'b1;
                    for (int m = i - 1; m >= 0; m--) begin
                        v_acc = v_acc | (w_g[4*j+m] & v_pp);
                        v_pp  = v_pp & w_p[4*j+m];
                    end
                    w_c[4*j+i] = v_acc | (v_pp & w_gc[j]);
                end
            end
            w_x[k*STAGE_BITS +: STAGE_BITS] = w_p ^ w_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= g_stage[LAT-1].v_q;
            s_q         <= g_stage[LAT-1].w_x;
            co_q        <= g_stage[LAT-1].w_gc[NG];
            ov_q        <= g_stage[LAT-1].w_gc[NG] ^ g_stage[LAT-1].w_c[STAGE_BITS-1];
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ov        = ov_q;
endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipe
//  Purpose  : Self-checking bench for cla_pipe (32/8, 16/4 and 64/16 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ov;
    logic [31:0] a, b, s;

    logic        v16_in, r16_in, ci16, sub16, v16_out, co16, ov16;
    logic [15:0] a16, b16, s16;
    logic        v64_in, r64_in, ci64, sub64, v64_out, co64, ov64;
    logic [63:0] a64, b64, s64;
    logic        ro_sw;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe #(.WIDTH(32), .STAGE_BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ov(ov));

    cla_pipe #(.WIDTH(16), .STAGE_BITS(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(v16_in), .in_ready(r16_in),
        .a(a16), .b(b16), .ci(ci16), .sub(sub16), .out_valid(v16_out),
        .out_ready(ro_sw), .s(s16), .co(co16), .ov(ov16));

    cla_pipe #(.WIDTH(64), .STAGE_BITS(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(v64_in), .in_ready(r64_in),
        .a(a64), .b(b64), .ci(ci64), .sub(sub64), .out_valid(v64_out),
        .out_ready(ro_sw), .s(s64), .co(co64), .ov(ov64));

    // Reference: {carry_out, signed_overflow, sum} from integer arithmetic.
    function automatic logic [65:0] model(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input logic cin,
                                          input logic md);
        logic [63:0]        mask;
        logic [64:0]        u;
        logic signed [67:0] sx, sy, ss, lim;
        logic               cout, ovf;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = x & mask;
        y = y & mask;
        if (md) begin
            u    = {1'b0, x} - {1'b0, y};
            cout = (x >= y);
        end else begin
            u    = {1'b0, x} + {1'b0, y} + {64'd0, cin};
            cout = u[w];
        end
        sx  = $signed({4'd0, x}) - (x[w-1] ? (68'sd1 <<< w) : 68'sd0);
        sy  = $signed({4'd0, y}) - (y[w-1] ? (68'sd1 <<< w) : 68'sd0);
        ss  = md ? (sx - sy) : (sx + sy + (cin ? 68'sd1 : 68'sd0));
        lim = 68'sd1 <<< (w - 1);
        ovf = (ss >= lim) || (ss < -lim);
        return {cout, ovf, u[63:0] & mask};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set to the 32-bit unit and collects its result.
    task automatic send_and_wait(input logic [31:0] xa, input logic [31:0] xb,
                                 input logic xci, input logic xsub,
                                 output logic [31:0] rs, output logic rco,
                                 output logic rov, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = xa; b = xb; ci = xci; sub = xsub;
        step();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; ci = ~xci; sub = ~xsub;
        lat = 0;
        while (!out_valid && lat < 12) begin
            step();
            lat++;
        end
        rs = s; rco = co; rov = ov;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (s !== 32'd0) begin errors++; $display("FAIL reset_s: got %h want 0", s); end
        checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b want 0", co); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b want 0", ov); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: cycle %0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_single();
        logic [31:0] rs; logic rco, rov; int lat;
        send_and_wait(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rco, rov, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d want 4", lat); end
        checks++; if (rs !== 32'h0001_0000) begin errors++; $display("FAIL single_s: got %h want 00010000", rs); end
        checks++; if (rco !== 1'b0) begin errors++; $display("FAIL single_co: got %b want 0", rco); end
        checks++; if (rov !== 1'b0) begin errors++; $display("FAIL single_ov: got %b want 0", rov); end
    endtask

    task automatic test_corners();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] tb [3] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
        logic        tc [3] = '{1'b1, 1'b0, 1'b0};
        logic        tm [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] es [3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        logic        ec [3] = '{1'b1, 1'b1, 1'b0};
        logic        eo [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] rs; logic rco, rov; int lat;
        for (int i = 0; i < 3; i++) begin
            send_and_wait(ta[i], tb[i], tc[i], tm[i], rs, rco, rov, lat);
            checks++; if (rs !== es[i]) begin errors++; $display("FAIL corner%0d_s: got %h want %h", i, rs, es[i]); end
            checks++; if (rco !== ec[i]) begin errors++; $display("FAIL corner%0d_co: got %b want %b", i, rco, ec[i]); end
            checks++; if (rov !== eo[i]) begin errors++; $display("FAIL corner%0d_ov: got %b want %b", i, rov, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [65:0] expq[$];
        logic [65:0] e;
        logic [31:0] held_s;
        logic        held = 1'b0;
        logic        pend = 1'b0;
        int sent = 0, got = 0, guard = 0;
        while ((sent < 20 || expq.size() != 0 || pend) && guard < 400) begin
            guard++;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || s !== held_s) begin
                    errors++; $display("FAIL stream_hold: got valid=%b s=%h want valid=1 s=%h", out_valid, s, held_s);
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 20 && !pend) begin
                a = $urandom; b = $urandom; ci = $urandom_range(0, 1); sub = $urandom_range(0, 1);
                pend = 1'b1;
            end
            in_valid = pend;
            #1;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stream_stall_in_ready: got %b want 0", in_ready); end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(32, {32'd0, a}, {32'd0, b}, ci, sub));
                sent++;
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL stream_extra: unexpected result s=%h", s);
                end else begin
                    e = expq.pop_front();
                    if ({co, ov, 32'd0, s} !== e) begin
                        errors++; $display("FAIL stream_data: got co=%b ov=%b s=%h want co=%b ov=%b s=%h",
                                           co, ov, s, e[65], e[64], e[31:0]);
                    end
                end
                got++;
            end
            held   = out_valid && !out_ready;
            held_s = s;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 20 || guard >= 400) begin errors++; $display("FAIL stream_count: got %0d results want 20", got); end
    endtask

    task automatic test_reset_midflight();
        logic [65:0] e;
        logic [31:0] rs; logic rco, rov; int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = $urandom; b = $urandom; ci = 1'b0; sub = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: cycle %0d got %b want 0", i, out_valid); end
            step();
        end
        e = model(32, 64'h1234_5678, 64'h0FED_CBA9, 1'b1, 1'b0);
        send_and_wait(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, rs, rco, rov, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL midreset_latency: got %0d want 4", lat); end
        checks++;
        if ({rco, rov, 32'd0, rs} !== e) begin
            errors++; $display("FAIL midreset_data: got co=%b ov=%b s=%h want co=%b ov=%b s=%h", rco, rov, rs, e[65], e[64], e[31:0]);
        end
    endtask

    task automatic test_sweep();
        logic [65:0] q16[$], q64[$];
        int          t16[$], t64[$];
        logic [65:0] e;
        logic [63:0] xa, xb;
        logic        xc, xs;
        int          st;
        int          n = 0;
        ro_sw = 1'b1;
        for (int cy = 0; cy < 1013; cy++) begin
            if (v16_out) begin
                checks++;
                if (q16.size() == 0) begin
                    errors++; $display("FAIL sweep16_extra: unexpected result s=%h", s16);
                end else begin
                    e = q16.pop_front(); st = t16.pop_front();
                    if ({co16, ov16, 48'd0, s16} !== e || cyc - st != 4) begin
                        errors++; $display("FAIL sweep16_data: got co=%b ov=%b s=%h lat=%0d want co=%b ov=%b s=%h lat=4",
                                           co16, ov16, s16, cyc - st, e[65], e[64], e[15:0]);
                    end
                end
            end
            if (v64_out) begin
                checks++;
                if (q64.size() == 0) begin
                    errors++; $display("FAIL sweep64_extra: unexpected result s=%h", s64);
                end else begin
                    e = q64.pop_front(); st = t64.pop_front();
                    if ({co64, ov64, s64} !== e || cyc - st != 4) begin
                        errors++; $display("FAIL sweep64_data: got co=%b ov=%b s=%h lat=%0d want co=%b ov=%b s=%h lat=4",
                                           co64, ov64, s64, cyc - st, e[65], e[64], e[63:0]);
                    end
                end
            end
            if (n < 1003) begin
                case (n)
                    0:       begin xa = {64{1'b1}}; xb = 64'd1; xc = 1'b0; xs = 1'b0; end
                    1:       begin xa = 64'h8000_0000_0000_0000; xb = 64'd1; xc = 1'b0; xs = 1'b1; end
                    2:       begin xa = 64'd0; xb = 64'd0; xc = 1'b1; xs = 1'b1; end
                    default: begin
                        xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
                        xc = $urandom_range(0, 1); xs = $urandom_range(0, 1);
                    end
                endcase
                v16_in = 1'b1; a16 = (n == 1) ? 16'h8000 : xa[15:0]; b16 = xb[15:0]; ci16 = xc; sub16 = xs;
                v64_in = 1'b1; a64 = xa; b64 = xb; ci64 = xc; sub64 = xs;
                checks++;
                if (r16_in !== 1'b1 || r64_in !== 1'b1) begin
                    errors++; $display("FAIL sweep_in_ready: got r16=%b r64=%b want 1 1", r16_in, r64_in);
                end
                q16.push_back(model(16, {48'd0, a16}, {48'd0, b16}, ci16, sub16));
                t16.push_back(cyc + 1);
                q64.push_back(model(64, a64, b64, ci64, sub64));
                t64.push_back(cyc + 1);
                n++;
            end else begin
                v16_in = 1'b0;
                v64_in = 1'b0;
            end
            step();
        end
        checks++;
        if (q16.size() != 0 || q64.size() != 0) begin
            errors++; $display("FAIL sweep_drain: got %0d/%0d pending want 0/0", q16.size(), q64.size());
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        v16_in = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sub16 = 1'b0;
        v64_in = 1'b0; a64 = '0; b64 = '0; ci64 = 1'b0; sub64 = 1'b0;
        ro_sw = 1'b1;
        test_reset();
        test_single();
        test_corners();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
